// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces an active-low push-button, producing
// a clean level, press/release strobes and a direction flag that toggles per press.
`default_nettype none

module key_conditioner #(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic INIT_DIR        = 1'b1
) (
  input  logic clock_5,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic dir_out
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             dir_q, dir_d;
  logic             ks;

  // Synchroniser resets to the released level so a held key is seen as a fresh press.
  assign ks = ~sync2_q;

  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      dir_q     <= INIT_DIR;
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      dir_q     <= dir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    dir_d     = dir_q;
    case (state_q)
      IDLE: begin
        if (ks) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!ks) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          press_d = 1'b1;
          dir_d   = ~dir_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!ks) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (ks) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign dir_out     = dir_q;

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed and random key stimulus against a run-length
// debounce model; strobes are checked through an expected-event scoreboard.
`default_nettype none

module tb_key_conditioner;

  localparam int   D    = 4;
  localparam logic IDIR = 1'b1;

  logic clock_5 = 1'b0;
  logic reset   = 1'b0;
  logic key_n   = 1'b1;
  logic key_level, key_press, key_release, dir_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    bit press;
    bit dir;
  } ev_t;
  ev_t exp_q[$];

  // Reference model: the accepted level flips once the synchronised key has
  // disagreed with it for D+1 consecutive sampled edges.
  bit m_s1 = 1'b1, m_s2 = 1'b1;
  bit m_level = 1'b0, m_dir = IDIR;
  int m_run = 0;
  int m_press_cnt = 0, m_rel_cnt = 0;
  int d_press_cnt = 0, d_rel_cnt = 0;

  always #5 clock_5 = ~clock_5;

  key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .INIT_DIR       (IDIR)
  ) dut (
    .clock_5    (clock_5),
    .reset      (reset),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .dir_out    (dir_out)
  );

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clock_5) begin
    bit ks;
    ev_t e;
    cyc++;
    if (!reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_dir = IDIR; m_run = 0;
    end else begin
      ks = ~m_s2;
      if (ks != m_level) m_run++;
      else m_run = 0;
      if (m_run == D + 1) begin
        m_level = ks;
        m_run   = 0;
        if (ks) begin
          m_dir = ~m_dir;
          m_press_cnt++;
        end else begin
          m_rel_cnt++;
        end
        e.cyc = cyc; e.press = ks; e.dir = m_dir;
        exp_q.push_back(e);
      end
      m_s2 = m_s1;
      m_s1 = key_n;
    end
  end

  // Monitor: samples 2 time units after each rising edge.
  always @(posedge clock_5) begin
    ev_t e;
    #2;
    if (!reset) begin
      chk("rst_level", key_level, 0);
      chk("rst_press", key_press, 0);
      chk("rst_release", key_release, 0);
      chk("rst_dir", dir_out, IDIR);
    end else begin
      if (key_press && key_release) chk("both_strobes", 1, 0);
      chk("level", key_level, m_level);
      chk("dir", dir_out, m_dir);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missed_strobe_cycle", cyc, e.cyc);
      end
      if (key_press) d_press_cnt++;
      if (key_release) d_rel_cnt++;
      if (key_press || key_release) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("strobe_kind_press", key_press, e.press);
          chk("strobe_dir", dir_out, e.dir);
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    key_n = v;
    repeat (n) @(negedge clock_5);
  endtask

  initial begin
    int e;
    reset = 1'b0;
    key_n = 1'b1;
    repeat (3) @(negedge clock_5);
    reset = 1'b1;

    // 1: idle after reset
    hold(1'b1, 20);
    chk("s1_level", key_level, 0);
    chk("s1_press", key_press, 0);
    chk("s1_dir", dir_out, 1);

    // 2: press latency E+6, then long hold with no further strobes
    key_n = 1'b0;
    e = cyc + 1;
    repeat (6) @(negedge clock_5);
    chk("s2_press_early", key_press, 0);
    @(negedge clock_5);
    chk("s2_press_edge", cyc, e + 6);
    chk("s2_press", key_press, 1);
    chk("s2_level", key_level, 1);
    chk("s2_dir", dir_out, 0);
    hold(1'b0, 20);
    chk("s2_press_once", d_press_cnt, 1);

    // 4: release latency R+6, then a 3-cycle release glitch from a fresh press
    key_n = 1'b1;
    e = cyc + 1;
    repeat (7) @(negedge clock_5);
    chk("s4_release_edge", cyc, e + 6);
    chk("s4_release", key_release, 1);
    chk("s4_level", key_level, 0);
    hold(1'b1, 5);

    // 3: 3-cycle bounce, then a clean 10-cycle press
    hold(1'b0, 3);
    hold(1'b1, 12);
    chk("s3_no_press", d_press_cnt, 1);
    chk("s3_dir", dir_out, 0);
    hold(1'b0, 10);
    hold(1'b0, 2);
    chk("s3_press", d_press_cnt, 2);
    hold(1'b1, 3);
    hold(1'b0, 12);
    chk("s4_glitch_no_release", d_rel_cnt, 1);
    chk("s4_glitch_level", key_level, 1);
    hold(1'b1, 12);

    // 5: three clean press/release pairs
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 12);
      hold(1'b1, 12);
    end
    chk("s5_presses", d_press_cnt, 5);
    chk("s5_releases", d_rel_cnt, 5);

    // 6: reset while PRESS_WAIT has counted to 2, key kept low
    hold(1'b0, 5);
    reset = 1'b0;
    repeat (2) @(negedge clock_5);
    chk("s6_no_press", d_press_cnt, 5);
    reset = 1'b1;
    e = cyc + 1;
    repeat (7) @(negedge clock_5);
    chk("s6_press_edge", cyc, e + 6);
    chk("s6_press", key_press, 1);
    hold(1'b0, 5);
    hold(1'b1, 12);

    // random bursts around the debounce threshold
    for (int i = 0; i < 60; i++) begin
      hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 2 * D + 3)));
    end
    hold(1'b1, 20);

    chk("total_presses", d_press_cnt, m_press_cnt);
    chk("total_releases", d_rel_cnt, m_rel_cnt);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
